vga_rom_pic_ctrl: RTL and testbench

Picture-window controller for the ROM-picture VGA path. It takes the pixel request stream from the VGA timing generator and decides, per pixel, whether the pixel lies inside the picture window. It sequences the picture ROM read address in raster order and returns either ROM data or the background colour, aligned to a fixed latency. Once per frame it moves the window origin in a bouncing pattern across the active area.

---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_pic_mover.sv | 101 ++++++++++
 rtl/vga_rom_pic_ctrl.sv | 145 ++++++++++++++
 tb/tb_vga_rom_pic_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the ROM-picture VGA path.
//   H_VALID / V_VALID : active area of the 640x480 raster
//   RGB565_*          : common RGB565 colours, BG_COLOR_DEF is the default
//                       background shown outside the picture window
//   dir_t             : per-axis movement direction (increment / decrement)
//   to_u11()          : zero-extends a 10-bit coordinate so window bounds
//                       can be formed without overflow
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int H_VALID = 640;
    localparam int V_VALID = 480;

    localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
    localparam logic [15:0] RGB565_BLACK = 16'h0000;
    localparam logic [15:0] RGB565_RED   = 16'hF800;
    localparam logic [15:0] RGB565_GREEN = 16'h07E0;
    localparam logic [15:0] RGB565_BLUE  = 16'h001F;

    localparam logic [15:0] BG_COLOR_DEF = RGB565_WHITE;

    // DIR_INC is RIGHT on the X axis and DOWN on the Y axis.
    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } dir_t;

    function automatic logic [10:0] to_u11(input logic [9:0] v);
        return {1'b0, v};
    endfunction

endpackage

// File: rtl/vga_pic_mover.sv
// ---------------------------------------------------------------------------
// vga_pic_mover
// Bouncing origin generator for the picture window. Each axis owns a
// direction FSM (DIR_INC / DIR_DEC) and an origin register. On a frame_end
// pulse with move_en high both axes step by STEP; an axis that would leave
// the active area is clamped to the edge and reverses. Both axes update in
// the same cycle, so a corner hit flips both directions at once.
//
// Ports
//   sys_clk   in   system clock
//   sys_rst   in   synchronous active-high reset (origin 0, directions INC)
//   frame_end in   once-per-frame pulse, the only update point
//   move_en   in   enables the update; origin/direction hold when low
//   org_x     out  window origin column
//   org_y     out  window origin line
// ---------------------------------------------------------------------------
module vga_pic_mover #(
    parameter int H_VALID = vga_pkg::H_VALID,
    parameter int V_VALID = vga_pkg::V_VALID,
    parameter int PIC_W   = 100,
    parameter int PIC_H   = 100,
    parameter int STEP    = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       frame_end,
    input  logic       move_en,
    output logic [9:0] org_x,
    output logic [9:0] org_y
);
    import vga_pkg::*;

    localparam logic [9:0]  STEP10 = 10'(STEP);
    localparam logic [11:0] STEP12 = 12'(STEP);

    logic [9:0] org_arr [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            // Highest legal origin on this axis: the window's far edge
            // lands exactly on the end of the active area.
            localparam int          LIMIT   = (gi == 0) ? (H_VALID - PIC_W)
                                                        : (V_VALID - PIC_H);
            localparam logic [9:0]  LIMIT10 = 10'(LIMIT);
            localparam logic [11:0] LIMIT12 = 12'(LIMIT);

            logic [9:0] org_reg;
            logic [9:0] org_next;
            dir_t       dir_reg;
            dir_t       dir_next;

            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    org_reg <= '0;
                    dir_reg <= DIR_INC;
                end else begin
                    org_reg <= org_next;
                    dir_reg <= dir_next;
                end
            end

            always_comb begin
                org_next = org_reg;
                dir_next = dir_reg;
                if (frame_end && move_en) begin
                    unique case (dir_reg)
                        DIR_INC: begin
                            // org+STEP+PIC > VALID  <=>  org+STEP > LIMIT;
                            // 12-bit sum so a large STEP cannot wrap.
                            if (({2'b00, org_reg} + STEP12) > LIMIT12) begin
                                org_next = LIMIT10;
                                dir_next = DIR_DEC;
                            end else begin
                                org_next = org_reg + STEP10;
                            end
                        end
                        DIR_DEC: begin
                            if (org_reg < STEP10) begin
                                org_next = '0;
                                dir_next = DIR_INC;
                            end else begin
                                org_next = org_reg - STEP10;
                            end
                        end
                        default: begin
                            org_next = org_reg;
                            dir_next = dir_reg;
                        end
                    endcase
                end
            end

            assign org_arr[gi] = org_reg;
        end
    endgenerate

    assign org_x = org_arr[0];
    assign org_y = org_arr[1];

endmodule

// File: rtl/vga_rom_pic_ctrl.sv
// ---------------------------------------------------------------------------
// vga_rom_pic_ctrl
// Picture-window controller for the ROM-picture VGA path. For each pixel
// request it decides whether the pixel is inside the picture window, walks
// the ROM address in raster order over the window, and returns ROM data or
// the background colour with a fixed 3-cycle latency.
//
// Latency for a pix_req in cycle N:
//   N+1  rom_addr / rom_rd_en registered
//   N+2  rom_rdata from the 1-cycle synchronous ROM
//   N+3  pix_data registered
//
// Ports
//   sys_clk    in   system clock
//   sys_rst    in   synchronous active-high reset
//   pix_req    in   pixel request, one per active pixel
//   pix_x/y    in   coordinates of the requested pixel
//   frame_end  in   per-frame pulse: clears the address counter and lets the
//                   origin mover step
//   move_en    in   enables the per-frame origin movement
//   rom_rdata  in   ROM read data
//   rom_addr   out  ROM read address
//   rom_rd_en  out  ROM read strobe, high for in-window requests only
//   pix_data   out  RGB565 pixel
//   org_x/y    out  current window origin
// ---------------------------------------------------------------------------
module vga_rom_pic_ctrl #(
    parameter int          H_VALID  = vga_pkg::H_VALID,
    parameter int          V_VALID  = vga_pkg::V_VALID,
    parameter int          PIC_W    = 100,
    parameter int          PIC_H    = 100,
    parameter int          ADDR_W   = 14,
    parameter int          STEP     = 1,
    parameter logic [15:0] BG_COLOR = vga_pkg::BG_COLOR_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              pix_req,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic              frame_end,
    input  logic              move_en,
    input  logic [15:0]       rom_rdata,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd_en,
    output logic [15:0]       pix_data,
    output logic [9:0]        org_x,
    output logic [9:0]        org_y
);
    import vga_pkg::*;

    localparam logic [10:0] PIC_W11 = 11'(PIC_W);
    localparam logic [10:0] PIC_H11 = 11'(PIC_H);

    logic [9:0]        org_x_int;
    logic [9:0]        org_y_int;

    logic [10:0]       px;
    logic [10:0]       py;
    logic [10:0]       ox;
    logic [10:0]       oy;
    logic              in_x;
    logic              in_y;
    logic              in_win;

    logic [ADDR_W-1:0] addr_cnt_reg;
    logic [ADDR_W-1:0] addr_cnt_next;
    logic [ADDR_W-1:0] rom_addr_reg;
    logic [2:1]        win_pipe_reg;
    logic [15:0]       pix_data_reg;

    // ---------------- origin mover ----------------
    vga_pic_mover #(
        .H_VALID (H_VALID),
        .V_VALID (V_VALID),
        .PIC_W   (PIC_W),
        .PIC_H   (PIC_H),
        .STEP    (STEP)
    ) u_mover (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .frame_end (frame_end),
        .move_en   (move_en),
        .org_x     (org_x_int),
        .org_y     (org_y_int)
    );

    // ---------------- window compare ----------------
    // Bounds are formed at 11 bits so org+PIC never wraps. The origin used
    // here is the registered one, so a request in the frame_end cycle is
    // still tested against the pre-update origin.
    assign px   = to_u11(pix_x);
    assign py   = to_u11(pix_y);
    assign ox   = to_u11(org_x_int);
    assign oy   = to_u11(org_y_int);
    assign in_x = (px >= ox) && (px < (ox + PIC_W11));
    assign in_y = (py >= oy) && (py < (oy + PIC_H11));
    assign in_win = pix_req && in_x && in_y;

    // ---------------- address counter ----------------
    // frame_end takes priority so the next frame always starts at 0, even
    // when the last in-window request shares the cycle with frame_end.
    always_comb begin
        addr_cnt_next = addr_cnt_reg;
        if (frame_end) begin
            addr_cnt_next = '0;
        end else if (in_win) begin
            addr_cnt_next = addr_cnt_reg + ADDR_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            addr_cnt_reg <= '0;
            rom_addr_reg <= '0;
        end else begin
            addr_cnt_reg <= addr_cnt_next;
            // Only load on a served request so the ROM address bus stays
            // quiet outside the window.
            if (in_win) begin
                rom_addr_reg <= addr_cnt_reg;
            end
        end
    end

    // ---------------- in-window flag pipeline + output mux ----------------
    // Stage 1 doubles as the ROM read strobe, stage 2 lines up with
    // rom_rdata, and the third stage is the pix_data register itself.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            win_pipe_reg <= '0;
            pix_data_reg <= BG_COLOR;
        end else begin
            win_pipe_reg <= {win_pipe_reg[1], in_win};
            pix_data_reg <= win_pipe_reg[2] ? rom_rdata : BG_COLOR;
        end
    end

    assign rom_addr  = rom_addr_reg;
    assign rom_rd_en = win_pipe_reg[1];
    assign pix_data  = pix_data_reg;
    assign org_x     = org_x_int;
    assign org_y     = org_y_int;

endmodule

// File: tb/tb_vga_rom_pic_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_rom_pic_ctrl
// Directed bench for vga_rom_pic_ctrl. A default-parameter instance sees
// windowed raster frames with a data=address ROM; a STEP=7 instance shares
// the control inputs and is used for the edge-clamp behaviour of the mover.
// ---------------------------------------------------------------------------
module tb_vga_rom_pic_ctrl;

    localparam logic [15:0] BG = 16'hFFFF;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        pix_req;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        frame_end;
    logic        move_en;

    logic [15:0] rom_rdata;
    logic [13:0] rom_addr;
    logic        rom_rd_en;
    logic [15:0] pix_data;
    logic [9:0]  org_x;
    logic [9:0]  org_y;

    logic [15:0] rom7_rdata;
    logic [13:0] rom_addr7;
    logic        rom_rd_en7;
    logic [15:0] pix_data7;
    logic [9:0]  org_x7;
    logic [9:0]  org_y7;

    always #10 sys_clk = ~sys_clk;

    vga_rom_pic_ctrl dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .pix_req   (pix_req),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .frame_end (frame_end),
        .move_en   (move_en),
        .rom_rdata (rom_rdata),
        .rom_addr  (rom_addr),
        .rom_rd_en (rom_rd_en),
        .pix_data  (pix_data),
        .org_x     (org_x),
        .org_y     (org_y)
    );

    vga_rom_pic_ctrl #(.STEP(7)) dut7 (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .pix_req   (pix_req),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .frame_end (frame_end),
        .move_en   (move_en),
        .rom_rdata (rom7_rdata),
        .rom_addr  (rom_addr7),
        .rom_rd_en (rom_rd_en7),
        .pix_data  (pix_data7),
        .org_x     (org_x7),
        .org_y     (org_y7)
    );

    // 1-cycle synchronous ROMs whose contents equal their address.
    always @(posedge sys_clk) begin
        rom_rdata  <= {2'b00, rom_addr};
        rom7_rdata <= {2'b00, rom_addr7};
    end

    // ---------------- reference model (origin fixed at 0,0) ----------------
    int          n_checks = 0;
    int          n_errs   = 0;
    int          cyc      = 0;
    int          cnt_rd   = 0;
    bit          rst_exact = 1'b1;

    logic        m_win;
    logic        m_valid;
    logic [13:0] m_cnt;
    logic        s_win  [1:3];
    logic        s_chk  [1:3];
    logic [13:0] s_addr [1:3];

    assign m_win = pix_req && (pix_x < 10'd100) && (pix_y < 10'd100);

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            m_cnt   <= '0;
            m_valid <= rst_exact;
            for (int i = 1; i <= 3; i++) begin
                s_win[i]  <= 1'b0;
                s_chk[i]  <= 1'b0;
                s_addr[i] <= '0;
            end
        end else begin
            s_win[1]  <= m_win;
            s_addr[1] <= m_cnt;
            s_chk[1]  <= m_valid;
            for (int i = 2; i <= 3; i++) begin
                s_win[i]  <= s_win[i-1];
                s_addr[i] <= s_addr[i-1];
                s_chk[i]  <= s_chk[i-1];
            end
            if (frame_end) begin
                m_cnt   <= '0;
                m_valid <= 1'b1;
            end else if (m_win) begin
                m_cnt <= m_cnt + 14'd1;
            end
        end
    end

    // Directed pixel probes: cycle at which pix_data must hold the value.
    int          pr_cyc [3];
    logic [15:0] pr_exp [3];
    string       pr_tag [3];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h) at cycle %0d",
                     tag, act, act, exp, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, compare at negedge.
    task automatic tick(input logic req, input int x, input int y,
                        input logic fe, input logic rst);
        @(posedge sys_clk);
        #1;
        cyc++;
        sys_rst   = rst;
        pix_req   = req;
        pix_x     = x[9:0];
        pix_y     = y[9:0];
        frame_end = fe;
        @(negedge sys_clk);
        if (rom_rd_en) cnt_rd++;
        if (s_chk[1]) begin
            check("rd_en", {31'd0, rom_rd_en}, {31'd0, s_win[1]});
            if (s_win[1]) check("rom_addr", {18'd0, rom_addr}, {18'd0, s_addr[1]});
        end
        if (s_chk[3]) begin
            check("pix_data", {16'd0, pix_data},
                  {16'd0, (s_win[3] ? {2'b00, s_addr[3]} : BG)});
        end
        for (int i = 0; i < 3; i++) begin
            if (pr_cyc[i] == cyc) check(pr_tag[i], {16'd0, pix_data}, {16'd0, pr_exp[i]});
        end
    endtask

    // Raster over rows x cols starting at (0,0). frame_end either rides on
    // the last request or follows in its own cycle. rst_line >= 0 pulses
    // sys_rst just before that line starts.
    task automatic scan(input int rows, input int cols, input bit fe_last,
                        input int rst_line, input bit probes);
        for (int y = 0; y < rows; y++) begin
            for (int x = 0; x < cols; x++) begin
                bit last;
                last = (y == rows - 1) && (x == cols - 1);
                if (y == rst_line && x == 0) tick(1'b0, 0, 0, 1'b0, 1'b1);
                if (probes) begin
                    if (x == 5   && y == 2)   pr_cyc[0] = cyc + 4;
                    if (x == 100 && y == 0)   pr_cyc[1] = cyc + 4;
                    if (x == 0   && y == 100) pr_cyc[2] = cyc + 4;
                end
                tick(1'b1, x, y, fe_last && last, 1'b0);
                if (y == rst_line && x == 0) begin
                    check("mid_rst_rom_addr", {18'd0, rom_addr}, 32'd0);
                    check("mid_rst_rd_en", {31'd0, rom_rd_en}, 32'd0);
                    check("mid_rst_pix", {16'd0, pix_data}, {16'd0, BG});
                    check("mid_rst_org_x", {22'd0, org_x}, 32'd0);
                    check("mid_rst_org_y", {22'd0, org_y}, 32'd0);
                end
            end
        end
        if (!fe_last) tick(1'b0, 0, 0, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        sys_rst   = 1'b1;
        pix_req   = 1'b0;
        pix_x     = '0;
        pix_y     = '0;
        frame_end = 1'b0;
        move_en   = 1'b0;
        for (int i = 0; i < 3; i++) pr_cyc[i] = -1;
        pr_tag[0] = "pix_5_2";    pr_exp[0] = 16'd205;
        pr_tag[1] = "pix_100_0";  pr_exp[1] = BG;
        pr_tag[2] = "pix_0_100";  pr_exp[2] = BG;

        // ---- reset state ----
        for (int i = 0; i < 3; i++) tick(1'b0, 0, 0, 1'b0, 1'b1);
        tick(1'b0, 0, 0, 1'b0, 1'b0);
        check("rst_rom_addr", {18'd0, rom_addr}, 32'd0);
        check("rst_rd_en", {31'd0, rom_rd_en}, 32'd0);
        check("rst_pix", {16'd0, pix_data}, {16'd0, BG});
        check("rst_org_x", {22'd0, org_x}, 32'd0);
        check("rst_org_y", {22'd0, org_y}, 32'd0);
        check("rst7_rom_addr", {18'd0, rom_addr7}, 32'd0);
        check("rst7_rd_en", {31'd0, rom_rd_en7}, 32'd0);
        check("rst7_pix", {16'd0, pix_data7}, {16'd0, BG});

        // ---- frame A: window plus its borders, probes armed ----
        cnt_rd = 0;
        scan(102, 102, 1'b0, -1, 1'b1);
        idle(3);
        check("frame_a_rd_pulses", cnt_rd, 32'd10000);
        check("hold_org_x", {22'd0, org_x}, 32'd0);
        check("hold_org_y", {22'd0, org_y}, 32'd0);

        // ---- frame B: frame_end coincides with the last in-window request ----
        cnt_rd = 0;
        scan(100, 100, 1'b1, -1, 1'b0);
        tick(1'b0, 0, 0, 1'b0, 1'b0);
        check("last_rd_en", {31'd0, rom_rd_en}, 32'd1);
        check("last_rom_addr", {18'd0, rom_addr}, 32'd9999);
        check("frame_b_rd_pulses", cnt_rd, 32'd10000);
        tick(1'b1, 0, 0, 1'b0, 1'b0);
        tick(1'b0, 0, 0, 1'b0, 1'b0);
        check("next_first_rd_en", {31'd0, rom_rd_en}, 32'd1);
        check("next_first_addr", {18'd0, rom_addr}, 32'd0);
        tick(1'b0, 0, 0, 1'b1, 1'b0);
        idle(3);

        // ---- frame D: reset pulsed at line 50, then exact frame E ----
        rst_exact = 1'b0;
        scan(102, 102, 1'b0, 50, 1'b0);
        idle(3);
        rst_exact = 1'b1;
        cnt_rd = 0;
        scan(102, 102, 1'b0, -1, 1'b0);
        idle(3);
        check("frame_e_rd_pulses", cnt_rd, 32'd10000);

        // ---- origin mover: STEP=1 (dut) and STEP=7 (dut7) ----
        move_en = 1'b1;
        for (int f = 1; f <= 542; f++) begin
            tick(1'b0, 0, 0, 1'b1, 1'b0);
            tick(1'b0, 0, 0, 1'b0, 1'b0);
            case (f)
                1:   begin check("s1_x_f1",   {22'd0, org_x}, 32'd1);   check("s1_y_f1",   {22'd0, org_y}, 32'd1);   end
                380: begin check("s1_x_f380", {22'd0, org_x}, 32'd380); check("s1_y_f380", {22'd0, org_y}, 32'd380); end
                381: begin check("s1_x_f381", {22'd0, org_x}, 32'd381); check("s1_y_f381", {22'd0, org_y}, 32'd380); end
                382: begin check("s1_x_f382", {22'd0, org_x}, 32'd382); check("s1_y_f382", {22'd0, org_y}, 32'd379); end
                539: begin check("s1_x_f539", {22'd0, org_x}, 32'd539); check("s1_y_f539", {22'd0, org_y}, 32'd222); end
                540: begin check("s1_x_f540", {22'd0, org_x}, 32'd540); check("s1_y_f540", {22'd0, org_y}, 32'd221); end
                541: begin check("s1_x_f541", {22'd0, org_x}, 32'd540); check("s1_y_f541", {22'd0, org_y}, 32'd220); end
                542: begin check("s1_x_f542", {22'd0, org_x}, 32'd539); check("s1_y_f542", {22'd0, org_y}, 32'd219); end
                default: ;
            endcase
            case (f)
                54:  begin check("s7_x_f54",  {22'd0, org_x7}, 32'd378); check("s7_y_f54",  {22'd0, org_y7}, 32'd378); end
                55:  begin check("s7_x_f55",  {22'd0, org_x7}, 32'd385); check("s7_y_f55",  {22'd0, org_y7}, 32'd380); end
                56:  begin check("s7_x_f56",  {22'd0, org_x7}, 32'd392); check("s7_y_f56",  {22'd0, org_y7}, 32'd373); end
                77:  begin check("s7_x_f77",  {22'd0, org_x7}, 32'd539); check("s7_y_f77",  {22'd0, org_y7}, 32'd226); end
                78:  begin check("s7_x_f78",  {22'd0, org_x7}, 32'd540); check("s7_y_f78",  {22'd0, org_y7}, 32'd219); end
                79:  begin check("s7_x_f79",  {22'd0, org_x7}, 32'd533); check("s7_y_f79",  {22'd0, org_y7}, 32'd212); end
                109: begin check("s7_x_f109", {22'd0, org_x7}, 32'd323); check("s7_y_f109", {22'd0, org_y7}, 32'd2);   end
                110: begin check("s7_x_f110", {22'd0, org_x7}, 32'd316); check("s7_y_f110", {22'd0, org_y7}, 32'd0);   end
                111: begin check("s7_x_f111", {22'd0, org_x7}, 32'd309); check("s7_y_f111", {22'd0, org_y7}, 32'd7);   end
                155: begin check("s7_x_f155", {22'd0, org_x7}, 32'd1);   check("s7_y_f155", {22'd0, org_y7}, 32'd315); end
                156: begin check("s7_x_f156", {22'd0, org_x7}, 32'd0);   check("s7_y_f156", {22'd0, org_y7}, 32'd322); end
                157: begin check("s7_x_f157", {22'd0, org_x7}, 32'd7);   check("s7_y_f157", {22'd0, org_y7}, 32'd329); end
                default: ;
            endcase
        end

        // With move_en low again the origin must hold across a frame_end.
        move_en = 1'b0;
        tick(1'b0, 0, 0, 1'b1, 1'b0);
        tick(1'b0, 0, 0, 1'b0, 1'b0);
        check("hold2_org_x", {22'd0, org_x}, 32'd539);
        check("hold2_org_y", {22'd0, org_y}, 32'd219);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
